// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external modular multiplier
module modexp_ctrl #(
    parameter int WIDTH = 256,
    parameter int EXP_W = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] mul_count,
    output logic             mul_en,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_n,
    input  logic [WIDTH-1:0] mul_r,
    input  logic             mul_valid
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MU_ISSUE,
        S_MU_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_base;
    logic [EXP_W-1:0] r_exp;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mul_en;
    logic [WIDTH-1:0] r_mul_b;

    logic             w_bit;
    logic             w_idx_zero;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [IDX_W-1:0] w_idx_dec;

    assign w_bit      = r_exp[r_idx];
    assign w_idx_zero = (r_idx == '0);
    assign w_idx_dec  = r_idx - IDX_W'(1);
    // Operation counter sticks at all-ones instead of wrapping
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    // The running product doubles as operand A, so it stays stable for the whole operation
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign mul_count = r_cnt;
    assign mul_en    = r_mul_en;
    assign mul_a     = r_acc;
    assign mul_b     = r_mul_b;
    assign mul_n     = r_n;

    // Sequencer: scan past leading zeros, then square per bit and multiply on set bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_mul_en <= 1'b0;
            r_mul_b  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_mul_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base   <= base;
                        r_exp    <= exp;
                        r_n      <= n;
                        r_acc    <= '0;
                        r_result <= '0;
                        r_err    <= 1'b0;
                        r_cnt    <= '0;
                        r_idx    <= IDX_W'(EXP_W - 1);
                        if ((n == '0) || (base >= n)) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (exp == '0) begin
                            r_result <= (n == WIDTH'(1)) ? '0 : WIDTH'(1);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_bit) begin
                        r_acc <= r_base;
                        if (w_idx_zero) begin
                            r_result <= r_base;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx    <= w_idx_dec;
                            r_mul_en <= 1'b1;
                            r_mul_b  <= r_base;
                            r_state  <= S_SQ_ISSUE;
                        end
                    end else begin
                        r_idx <= w_idx_dec;
                    end
                end
                S_SQ_ISSUE: begin
                    r_cnt   <= w_cnt_inc;
                    r_state <= S_SQ_WAIT;
                end
                S_SQ_WAIT: begin
                    if (mul_valid) begin
                        r_acc <= mul_r;
                        if (w_bit) begin
                            r_mul_en <= 1'b1;
                            r_mul_b  <= r_base;
                            r_state  <= S_MU_ISSUE;
                        end else if (w_idx_zero) begin
                            r_result <= mul_r;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx    <= w_idx_dec;
                            r_mul_en <= 1'b1;
                            r_mul_b  <= mul_r;
                            r_state  <= S_SQ_ISSUE;
                        end
                    end
                end
                S_MU_ISSUE: begin
                    r_cnt   <= w_cnt_inc;
                    r_state <= S_MU_WAIT;
                end
                S_MU_WAIT: begin
                    if (mul_valid) begin
                        r_acc <= mul_r;
                        if (w_idx_zero) begin
                            r_result <= mul_r;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx    <= w_idx_dec;
                            r_mul_en <= 1'b1;
                            r_mul_b  <= mul_r;
                            r_state  <= S_SQ_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - self-checking bench for modexp_ctrl with a behavioural modular multiplier
module tb_modexp_ctrl;

    localparam int WIDTH = 16;
    localparam int EXP_W = 8;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] base = '0;
    logic [EXP_W-1:0] exp = '0;
    logic [WIDTH-1:0] n = '0;
    logic             busy, done, err, mul_en, mul_valid;
    logic [WIDTH-1:0] result, mul_a, mul_b, mul_n, mul_r;
    logic [CNT_W-1:0] mul_count;

    logic             resp_valid = 1'b0;
    logic             spur_valid = 1'b0;
    logic [WIDTH-1:0] resp_r = '0;
    logic [WIDTH-1:0] spur_r = '0;

    assign mul_valid = resp_valid | spur_valid;
    assign mul_r     = spur_valid ? spur_r : resp_r;

    modexp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .n(n),
        .busy(busy), .done(done), .err(err), .result(result), .mul_count(mul_count),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
        .mul_r(mul_r), .mul_valid(mul_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the current job: expected multiplier operands in issue order plus final outputs
    longint q_a[$];
    longint q_b[$];
    longint m_n;
    longint e_result;
    int     e_err;
    int     e_cnt;
    int     en_seen = 0;
    int     done_seen = 0;
    int     op_k = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic plan_job(input longint b, input longint e, input longint m);
        int     top;
        longint r;
        q_a.delete();
        q_b.delete();
        m_n   = m;
        e_err = 0;
        e_cnt = 0;
        top   = 0;
        if (m == 0 || b >= m) begin
            e_err    = 1;
            e_result = 0;
        end else if (e == 0) begin
            e_result = (m == 1) ? 0 : 1;
        end else begin
            for (int i = 0; i < EXP_W; i++)
                if (((e >> i) & 1) != 0) top = i;
            r = b;
            for (int i = top - 1; i >= 0; i--) begin
                q_a.push_back(r);
                q_b.push_back(r);
                r = (r * r) % m;
                if (((e >> i) & 1) != 0) begin
                    q_a.push_back(r);
                    q_b.push_back(b);
                    r = (r * b) % m;
                end
            end
            e_result = r;
            e_cnt    = (q_a.size() > CNT_MAX) ? CNT_MAX : q_a.size();
        end
    endtask

    // Per-cycle compare of issued operations and completion outputs against the model
    always @(negedge clk) begin
        if (rst) begin
            if (mul_en) begin
                en_seen++;
                chk("en_while_busy", busy, 1);
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mul_en: got mul_en=1 expected no operation");
                end else begin
                    chk("mul_a", mul_a, q_a.pop_front());
                    chk("mul_b", mul_b, q_b.pop_front());
                    chk("mul_n", mul_n, m_n);
                end
            end
            if (done) begin
                done_seen++;
                chk("done_result", result, e_result);
                chk("done_err", err, e_err);
                chk("done_count", mul_count, e_cnt);
                chk("ops_left", q_a.size(), 0);
                chk("done_busy", busy, 0);
            end
        end
    end

    // Behavioural multiplier: latency 2..5 cycles, operands must hold steady until the result returns
    initial begin
        longint ca, cb, cn;
        int     lat;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (mul_en) begin
                ca  = mul_a;
                cb  = mul_b;
                cn  = mul_n;
                lat = 2 + (op_k % 4);
                op_k++;
                repeat (lat - 1) begin
                    @(negedge clk);
                    if (rst && busy) begin
                        chk("hold_a", mul_a, ca);
                        chk("hold_b", mul_b, cb);
                        chk("hold_n", mul_n, cn);
                    end
                end
                resp_r     = (cn != 0) ? WIDTH'((ca * cb) % cn) : '0;
                resp_valid = 1'b1;
            end
        end
    end

    task automatic run_job(input longint b, input longint e, input longint m,
                           input longint h_res, input int h_err, input int h_cnt,
                           input int h_ops, input bit spur, input bit intrude);
        int k;
        plan_job(b, e, m);
        chk("model_result", e_result, h_res);
        chk("model_count", e_cnt, h_cnt);
        en_seen = 0;
        @(negedge clk);
        base  = WIDTH'(b);
        exp   = EXP_W'(e);
        n     = WIDTH'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (spur) begin
            spur_r     = WIDTH'(123);
            spur_valid = 1'b1;
            @(negedge clk);
            spur_valid = 1'b0;
        end
        for (k = 0; k < 400 && !done; k++) begin
            if (intrude && k == 6) begin
                base  = WIDTH'(1);
                exp   = EXP_W'(3);
                n     = WIDTH'(5);
                start = 1'b1;
            end
            if (intrude && k == 7) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end else begin
            chk("hand_result", result, h_res);
            chk("hand_err", err, h_err);
            chk("hand_count", mul_count, h_cnt);
            chk("mul_en_pulses", en_seen, h_ops);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("result_held", result, h_res);
    endtask

    initial begin
        int k;
        int d0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_count", mul_count, 0);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_n", mul_n, 0);
        @(negedge clk);
        rst = 1'b1;

        // Stale multiplier pulse while idle must do nothing
        @(negedge clk);
        spur_r     = WIDTH'(77);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_done", done, 0);
        chk("spur_idle_result", result, 0);

        run_job(4, 13, 497, 445, 0, 5, 5, 1'b0, 1'b1);
        run_job(65, 17, 3233, 2790, 0, 5, 5, 1'b1, 1'b0);
        run_job(5, 0, 13, 1, 0, 0, 0, 1'b0, 1'b0);
        run_job(0, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        run_job(7, 1, 13, 7, 0, 0, 0, 1'b0, 1'b0);
        run_job(5, 3, 0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_job(13, 2, 13, 0, 1, 0, 0, 1'b0, 1'b0);
        run_job(3, 5, 7, 5, 0, 3, 3, 1'b0, 1'b0);
        run_job(3, 255, 1000, 507, 0, 7, 14, 1'b0, 1'b0);

        // Abort while waiting on the first square, then confirm the late result is ignored
        plan_job(4, 13, 497);
        d0 = done_seen;
        @(negedge clk);
        base  = WIDTH'(4);
        exp   = EXP_W'(13);
        n     = WIDTH'(497);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 50 && !mul_en; k++) @(negedge clk);
        chk("abort_saw_mul_en", mul_en, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_result", result, 0);
        chk("abort_count", mul_count, 0);
        chk("abort_mul_en", mul_en, 0);
        chk("abort_mul_a", mul_a, 0);
        chk("abort_mul_b", mul_b, 0);
        chk("abort_mul_n", mul_n, 0);
        q_a.delete();
        q_b.delete();
        #2;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("late_valid_busy", busy, 0);
        end
        chk("late_valid_no_done", done_seen, d0);
        chk("late_valid_result", result, 0);

        run_job(4, 13, 497, 445, 0, 5, 5, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
